// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI register block and its shift engine.
package spi_pkg;

    localparam int unsigned MAX_BYTES  = 4;
    localparam int unsigned BYTE_CNT_W = 3;
    localparam int unsigned BIT_CNT_W  = 3;

    // Control/status register bit positions owned by the register block
    localparam int unsigned CS_CPOL_BIT = 15;
    localparam int unsigned CS_CPHA_BIT = 14;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } spi_state_e;

    function automatic logic bytes_legal(input logic [BYTE_CNT_W-1:0] n);
        return (n != '0) && (n <= BYTE_CNT_W'(MAX_BYTES));
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while running and flags each
// toggle as a leading or trailing edge relative to the idle level.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic run_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic lead_stb_o,
    output logic trail_stb_o
);

    logic [7:0] cnt_q;
    logic       sclk_q;
    logic       tc;

    assign tc          = run_i && (cnt_q == 8'(CLK_DIV - 1));
    assign lead_stb_o  = tc && (sclk_q == cpol_i);
    assign trail_stb_o = tc && (sclk_q != cpol_i);
    assign sclk_o      = sclk_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!run_i) begin
            cnt_q  <= '0;
            sclk_q <= cpol_i;
        end else if (tc) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises the latched write word onto MOSI with CPOL/CPHA
// support and assembles MISO bytes into a 32-bit receive word with fill level.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic [31:0]           spi_write_data_i,
    input  logic [BYTE_CNT_W-1:0] spi_write_data_bytes_valid_i,
    input  logic                  reset_fill_level_i,
    input  logic                  spi_miso_i,
    output logic                  spi_mosi_o,
    output logic                  spi_clk_o,
    output logic [31:0]           spi_read_data_o,
    output logic [BYTE_CNT_W-1:0] spi_read_data_bytes_valid_o,
    output logic                  busy_o
);

    spi_state_e            state_q;
    logic                  en_q;
    logic [31:0]           tx_q;
    logic [BYTE_CNT_W-1:0] nbytes_q;
    logic [BYTE_CNT_W-1:0] byte_q;
    logic [BIT_CNT_W:0]    edge_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  mosi_q;
    logic [7:0]            rx_q;
    logic [31:0]           rdata_q;
    logic [BYTE_CNT_W-1:0] fill_q;

    logic       run;
    logic       cpol_sel;
    logic       lead_stb;
    logic       trail_stb;
    logic       edge_stb;
    logic       sample_stb;
    logic       shift_stb;
    logic       byte_done;
    logic       last_edge;
    logic [7:0] rx_next;

    assign run        = (state_q == StShift) && enable_i;
    assign cpol_sel   = (state_q == StIdle) ? cpol_i : cpol_q;
    assign edge_stb   = lead_stb || trail_stb;
    assign sample_stb = cpha_q ? trail_stb : lead_stb;
    assign shift_stb  = cpha_q ? lead_stb : trail_stb;
    assign rx_next    = {rx_q[6:0], spi_miso_i};
    // The 8th sample lands on edge 14 (CPHA=0) or edge 15 (CPHA=1) of the byte
    assign byte_done  = sample_stb && (edge_q == (cpha_q ? 4'd15 : 4'd14));
    assign last_edge  = edge_stb && (edge_q == 4'd15) && ((byte_q + 3'd1) == nbytes_q);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .run_i      (run),
        .cpol_i     (cpol_sel),
        .sclk_o     (spi_clk_o),
        .lead_stb_o (lead_stb),
        .trail_stb_o(trail_stb)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            tx_q     <= '0;
            nbytes_q <= '0;
            byte_q   <= '0;
            edge_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rx_q     <= '0;
            rdata_q  <= '0;
            fill_q   <= '0;
        end else begin
            en_q <= enable_i;

            if (reset_fill_level_i) begin
                rdata_q <= byte_done ? {24'b0, rx_next} : 32'b0;
                fill_q  <= byte_done ? 3'd1 : 3'd0;
            end else if (byte_done) begin
                rdata_q <= {rdata_q[23:0], rx_next};
                if (fill_q != BYTE_CNT_W'(MAX_BYTES)) begin
                    fill_q <= fill_q + 3'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    mosi_q <= 1'b0;
                    if (enable_i && !en_q && bytes_legal(spi_write_data_bytes_valid_i)) begin
                        tx_q     <= spi_write_data_i;
                        nbytes_q <= spi_write_data_bytes_valid_i;
                        cpol_q   <= cpol_i;
                        cpha_q   <= cpha_i;
                        mosi_q   <= spi_write_data_i[31];
                        byte_q   <= '0;
                        edge_q   <= '0;
                        rx_q     <= '0;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    if (!enable_i) begin
                        mosi_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (!enable_i) begin
                        mosi_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        if (sample_stb) begin
                            rx_q <= rx_next;
                        end
                        if (edge_stb) begin
                            edge_q <= edge_q + 4'd1;
                            if (edge_q == 4'd15) begin
                                byte_q <= byte_q + 3'd1;
                            end
                        end
                        if (last_edge) begin
                            state_q <= StDone;
                        end else if (shift_stb) begin
                            // CPHA=1 re-presents the current MSB; CPHA=0 moves to the next bit
                            mosi_q <= cpha_q ? tx_q[31] : tx_q[30];
                            tx_q   <= {tx_q[30:0], 1'b0};
                        end
                    end
                end
                StDone: begin
                    if (!enable_i) begin
                        mosi_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign spi_mosi_o                  = mosi_q;
    assign spi_read_data_o             = rdata_q;
    assign spi_read_data_bytes_valid_o = fill_q;
    assign busy_o                      = (state_q == StLoad) || (state_q == StShift);

endmodule
